morse_symbol_classifier: RTL and testbench
==========================================

# morse_symbol_classifier

Converts the debounced Morse key level into dots, dashes, letter boundaries and word boundaries, using the 100 ms time-unit pulse from the upstream unit timer as its only time base. It sits directly downstream of the unit timer and upstream of the letter lookup/display logic. It emits per-element pulses and, at each letter gap, a packed code of up to MAX_ELEMENTS elements with its length.

## Interface
- DASH_UNITS, 2: press of at least this many units is a dash; shorter is a dot.
- LETTER_GAP_UNITS, 3: key-up time that closes a letter.
- WORD_GAP_UNITS, 7: key-up time, measured from the last release, that closes a word. Must be greater than LETTER_GAP_UNITS.
- MAX_ELEMENTS, 5: maximum number of elements per letter.
- CNT_W, 4: width of the unit counter. The counter saturates at 2^CNT_W−1.

- clk, in, 1: system clock. One clock; reset is synchronous and active-high.
- rst, in, 1: synchronous, active-high reset.
- tick, in, 1: single-cycle unit pulse (100 ms).
- key_in, in, 1: debounced key level, already synchronous to clk; 1 = pressed.
- elem_valid, out, 1: one-cycle pulse when an element is classified.
- elem_dash, out, 1: element type, 1 = dash. Valid with elem_valid and held until the next elem_valid.
- letter_valid, out, 1: one-cycle pulse when a letter is closed.
- letter_code, out, MAX_ELEMENTS: element bits, 1 = dash. The first element is at bit letter_len−1 and the last at bit 0. Unused high bits are 0.
- letter_len, out, 3: number of elements, 1..MAX_ELEMENTS.
- letter_err, out, 1: the letter had more than MAX_ELEMENTS elements. Valid with letter_valid.
- word_end, out, 1: one-cycle pulse at the word gap.

## Operation
- FSM states: IDLE, PRESS, GAP, WORD_WAIT. Reset state is IDLE.
- Unit counter `cnt`:
  - Cleared on every state entry.
  - Incremented on tick and saturates at its maximum.
  - Effective duration at any cycle is `d = cnt + tick`.
- IDLE:
  - key_in=1 → PRESS, with the element buffer empty.
- PRESS:
  - On key_in=0, classify the element: dash if d ≥ DASH_UNITS, else dot. A press with d = 0 is a dot.
  - Pulse elem_valid and shift the element into the buffer: `buf <= {buf[MAX−2:0], dash}`, `len++`.
  - When the element would be element number MAX_ELEMENTS+1, the buffer and len are not changed and the sticky err bit is set instead.
  - Go to GAP.
- GAP:
  - If d == LETTER_GAP_UNITS:
    - Pulse letter_valid with buf, len and err.
    - Clear buf, len and err.
    - If key_in=1 → PRESS; otherwise → WORD_WAIT, with cnt continuing (not cleared).
  - Otherwise, if key_in=1 → PRESS. This continues the same letter.
- WORD_WAIT:
  - If d == WORD_GAP_UNITS (total key-up time since the release), pulse word_end.
    - key_in=1 → PRESS; otherwise → IDLE.
  - Otherwise, if key_in=1 → PRESS. This starts a new letter and no word_end is emitted.
- Priority: a gap threshold reached in a cycle is always reported before a simultaneous key press is acted on.
- IDLE never emits anything. A long silence after reset produces no letter and no word_end.
- Reset mid-operation:
  - All state is discarded: FSM to IDLE, cnt, buf, len and err cleared.
  - No partial letter is emitted.

## Timing
- All outputs are registered. A pulse is high for exactly one clk period, starting at the clk edge that samples the triggering key_in or tick.
- Nothing is output in the cycle of the key press itself. Latency from key release to elem_valid is 1 edge.
- letter_valid and word_end assert on the edge that samples the threshold tick.
- Reset values:
  - elem_valid, elem_dash, letter_valid, letter_err, word_end: 0.
  - letter_code: 0.
  - letter_len: 0.
- letter_code, letter_len and letter_err hold their values between letter_valid pulses.
- tick and key transitions are fully independent. Any alignment must work, including tick in the same cycle as press or release.

## Structure
- Shared package `morse_pkg`:
  - state enum.
  - default unit constants (DASH, LETTER_GAP, WORD_GAP, MAX_ELEMENTS).
  - letter_len width.
- This block is a single module; no sub-module is needed. The unit counter is inline. The element shift buffer is small enough to stay inline.

## Test plan
- Reset then press for 1 tick, release → elem_valid=1, elem_dash=0. Then 3 idle ticks → letter_valid, letter_code=5'b00000, letter_len=1 ("E").
- Press 3 ticks, gap 1, press 1, gap 1, press 3, gap 1, press 1, then 3 idle ticks → letter_code=5'b01010, letter_len=4 ("C"). Then 4 more ticks → word_end=1, with exactly one pulse.
- Six dots separated by 1-unit gaps → letter_len=5, letter_code=0, letter_err=1. Exactly six elem_valid pulses.
- Key pressed in the same cycle as the 3rd gap tick → letter_valid and the PRESS entry occur together. The next letter starts with len 0, and no word_end is emitted.
- Key released in the same cycle as tick after cnt=1 (d=2) → dash. Released with cnt=1 and no tick → dot.
- rst asserted mid-letter after 2 elements → all outputs 0 next cycle, no letter_valid afterward. A new press starts a fresh letter with len 1.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared types and default timing constants for the Morse keying path.
package morse_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS     = 2'd1,
    GAP       = 2'd2,
    WORD_WAIT = 2'd3
  } morse_state_e;

  localparam int unsigned DEF_DASH_UNITS       = 2;
  localparam int unsigned DEF_LETTER_GAP_UNITS = 3;
  localparam int unsigned DEF_WORD_GAP_UNITS   = 7;
  localparam int unsigned DEF_MAX_ELEMENTS     = 5;
  localparam int unsigned LEN_W                = 3;

endpackage

// File: rtl/morse_symbol_classifier.sv
// Turns the debounced key level into dot/dash pulses, packed letters and word
// boundaries, timed purely by the upstream unit tick.
module morse_symbol_classifier
  import morse_pkg::*;
#(
  parameter int unsigned DASH_UNITS       = DEF_DASH_UNITS,
  parameter int unsigned LETTER_GAP_UNITS = DEF_LETTER_GAP_UNITS,
  parameter int unsigned WORD_GAP_UNITS   = DEF_WORD_GAP_UNITS,
  parameter int unsigned MAX_ELEMENTS     = DEF_MAX_ELEMENTS,
  parameter int unsigned CNT_W            = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick,
  input  logic                    key_in,
  output logic                    elem_valid,
  output logic                    elem_dash,
  output logic                    letter_valid,
  output logic [MAX_ELEMENTS-1:0] letter_code,
  output logic [LEN_W-1:0]        letter_len,
  output logic                    letter_err,
  output logic                    word_end
);

  localparam int unsigned D_W = CNT_W + 1;

  morse_state_e            state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [MAX_ELEMENTS-1:0] buf_q, buf_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic                    err_q, err_d;
  logic [D_W-1:0]          d;
  logic                    is_dash;

  logic                    elem_valid_d, elem_dash_d, letter_valid_d, letter_err_d, word_end_d;
  logic [MAX_ELEMENTS-1:0] letter_code_d;
  logic [LEN_W-1:0]        letter_len_d;

  // State register plus registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      buf_q        <= '0;
      len_q        <= '0;
      err_q        <= 1'b0;
      elem_valid   <= 1'b0;
      elem_dash    <= 1'b0;
      letter_valid <= 1'b0;
      letter_code  <= '0;
      letter_len   <= '0;
      letter_err   <= 1'b0;
      word_end     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      buf_q        <= buf_d;
      len_q        <= len_d;
      err_q        <= err_d;
      elem_valid   <= elem_valid_d;
      elem_dash    <= elem_dash_d;
      letter_valid <= letter_valid_d;
      letter_code  <= letter_code_d;
      letter_len   <= letter_len_d;
      letter_err   <= letter_err_d;
      word_end     <= word_end_d;
    end
  end

  assign d       = D_W'(cnt_q) + D_W'(tick);
  assign is_dash = (d >= D_W'(DASH_UNITS));

  // Next-state, counter, buffer and output logic
  always_comb begin
    state_d        = state_q;
    cnt_d          = (tick && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + CNT_W'(1) : cnt_q;
    buf_d          = buf_q;
    len_d          = len_q;
    err_d          = err_q;
    elem_valid_d   = 1'b0;
    elem_dash_d    = elem_dash;
    letter_valid_d = 1'b0;
    letter_code_d  = letter_code;
    letter_len_d   = letter_len;
    letter_err_d   = letter_err;
    word_end_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (key_in) begin
          state_d = PRESS;
          cnt_d   = '0;
          buf_d   = '0;
          len_d   = '0;
          err_d   = 1'b0;
        end
      end

      PRESS: begin
        if (!key_in) begin
          elem_valid_d = 1'b1;
          elem_dash_d  = is_dash;
          // Overflowing elements leave the buffer intact and flag the letter
          if (len_q == LEN_W'(MAX_ELEMENTS)) begin
            err_d = 1'b1;
          end else begin
            buf_d = {buf_q[MAX_ELEMENTS-2:0], is_dash};
            len_d = len_q + LEN_W'(1);
          end
          state_d = GAP;
          cnt_d   = '0;
        end
      end

      GAP: begin
        if (d == D_W'(LETTER_GAP_UNITS)) begin
          letter_valid_d = 1'b1;
          letter_code_d  = buf_q;
          letter_len_d   = len_q;
          letter_err_d   = err_q;
          buf_d          = '0;
          len_d          = '0;
          err_d          = 1'b0;
          // Key-up time keeps accumulating toward the word gap
          if (key_in) begin
            state_d = PRESS;
            cnt_d   = '0;
          end else begin
            state_d = WORD_WAIT;
          end
        end else if (key_in) begin
          state_d = PRESS;
          cnt_d   = '0;
        end
      end

      WORD_WAIT: begin
        if (d == D_W'(WORD_GAP_UNITS)) begin
          word_end_d = 1'b1;
          state_d    = key_in ? PRESS : IDLE;
          cnt_d      = '0;
        end else if (key_in) begin
          state_d = PRESS;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_morse_symbol_classifier.sv
// Directed bench for morse_symbol_classifier with hand-computed expectations.
module tb_morse_symbol_classifier;
  import morse_pkg::*;

  logic       clk = 1'b0;
  logic       rst, tick, key_in;
  logic       elem_valid, elem_dash, letter_valid, letter_err, word_end;
  logic [4:0] letter_code;
  logic [2:0] letter_len;

  int n_tests = 0;
  int n_fail  = 0;
  int n_elem, n_letter, n_word;

  morse_symbol_classifier dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .key_in       (key_in),
    .elem_valid   (elem_valid),
    .elem_dash    (elem_dash),
    .letter_valid (letter_valid),
    .letter_code  (letter_code),
    .letter_len   (letter_len),
    .letter_err   (letter_err),
    .word_end     (word_end)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive on the falling edge, observe 1ns after the rising edge
  task automatic step(input logic k, input logic t);
    @(negedge clk);
    key_in = k;
    tick   = t;
    @(posedge clk);
    #1;
    if (elem_valid)   n_elem++;
    if (letter_valid) n_letter++;
    if (word_end)     n_word++;
  endtask

  task automatic press_units(input int n);
    step(1'b1, 1'b0);
    repeat (n) step(1'b1, 1'b1);
  endtask

  task automatic rel();
    step(1'b0, 1'b0);
  endtask

  task automatic gap_ticks(input int n);
    repeat (n) step(1'b0, 1'b1);
  endtask

  task automatic clear_counts();
    n_elem = 0; n_letter = 0; n_word = 0;
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; key_in = 1'b0;
    clear_counts();
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    check("rst_outputs", {elem_valid, elem_dash, letter_valid, letter_err, word_end, letter_code, letter_len}, 32'd0);
    rst = 1'b0;

    // E
    clear_counts();
    press_units(1);
    check("e_no_out_during_press", n_elem, 0);
    rel();
    check("e_elem_valid", elem_valid, 1);
    check("e_elem_dot", elem_dash, 0);
    gap_ticks(3);
    check("e_letter_valid", letter_valid, 1);
    check("e_code", letter_code, 5'b00000);
    check("e_len", letter_len, 1);
    check("e_err", letter_err, 0);
    gap_ticks(4);
    check("e_word_end", word_end, 1);
    check("e_letter_hold", letter_len, 1);

    // C = -.-.
    clear_counts();
    press_units(3); rel();
    check("c_first_dash", elem_dash, 1);
    gap_ticks(1);
    press_units(1); rel(); gap_ticks(1);
    press_units(3); rel(); gap_ticks(1);
    press_units(1); rel();
    gap_ticks(3);
    check("c_letter_valid", letter_valid, 1);
    check("c_code", letter_code, 5'b01010);
    check("c_len", letter_len, 4);
    check("c_elems", n_elem, 4);
    gap_ticks(3);
    check("c_no_early_word", n_word, 0);
    gap_ticks(1);
    check("c_word_end", word_end, 1);
    gap_ticks(12);
    check("c_one_word_end", n_word, 1);
    check("c_idle_silent", n_letter, 1);

    // Six dots overflow
    clear_counts();
    repeat (5) begin
      press_units(1); rel(); gap_ticks(1);
    end
    press_units(1); rel();
    gap_ticks(3);
    check("ovf_len", letter_len, 5);
    check("ovf_code", letter_code, 5'b00000);
    check("ovf_err", letter_err, 1);
    check("ovf_elems", n_elem, 6);
    gap_ticks(4);

    // Press lands on the third gap tick
    clear_counts();
    press_units(1); rel();
    gap_ticks(2);
    step(1'b1, 1'b1);
    check("sim_letter_valid", letter_valid, 1);
    check("sim_letter_len", letter_len, 1);
    step(1'b1, 1'b1); rel();
    check("sim_new_elem", elem_valid, 1);
    gap_ticks(3);
    check("sim_next_len", letter_len, 1);
    check("sim_next_err", letter_err, 0);
    check("sim_no_word", n_word, 0);
    check("sim_letters", n_letter, 2);
    gap_ticks(4);

    // Release alignment with tick: dash then dot (N = 10)
    clear_counts();
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    check("align_dash", elem_dash, 1);
    gap_ticks(1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    check("align_dot", elem_dash, 0);
    check("align_dot_valid", elem_valid, 1);
    gap_ticks(3);
    check("align_code", letter_code, 5'b00010);
    check("align_len", letter_len, 2);
    gap_ticks(4);

    // Reset mid-letter
    clear_counts();
    press_units(1); rel(); gap_ticks(1);
    press_units(3);
    rst = 1'b1;
    step(1'b0, 1'b0);
    check("mid_rst_outputs", {elem_valid, elem_dash, letter_valid, letter_err, word_end, letter_code, letter_len}, 32'd0);
    rst = 1'b0;
    clear_counts();
    gap_ticks(10);
    check("mid_rst_no_letter", n_letter, 0);
    check("mid_rst_no_word", n_word, 0);
    press_units(1); rel();
    gap_ticks(3);
    check("mid_rst_fresh_valid", letter_valid, 1);
    check("mid_rst_fresh_len", letter_len, 1);
    check("mid_rst_fresh_code", letter_code, 5'b00000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
